// File: rtl/lbp_pkg.sv
// lbp_pkg: shared frame geometry, pixel struct, engine states and the gray divider
package lbp_pkg;
  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int ADDR_W = 14;
  localparam int WIN_LEN = 2 * IMG_W + 3;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = ADDR_W - COL_W;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_t;
  // floor(s/3) for s <= 765: 683/2048 overshoots 1/3 by < 1/3 LSB over that range
  function automatic logic [7:0] div3(input logic [9:0] s);
    return 8'((20'(s) * 20'd683) >> 11);
  endfunction
endpackage

// File: rtl/lbp_window.sv
// lbp_window: two-line-plus-three gray shift buffer exposing the 3x3 taps of the pixel 129 behind the newest one
module lbp_window
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift,
  input  logic [7:0]        din,
  input  logic [ADDR_W-1:0] addr,
  output logic [8:0][7:0]   taps,
  output logic [ADDR_W-1:0] center,
  output logic              center_ok,
  output logic [ROW_W-1:0]  center_row,
  output logic [COL_W-1:0]  center_col
);
  logic [7:0] win [WIN_LEN];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < WIN_LEN; i++) win[i] <= '0;
      center <= '0;
      center_ok <= 1'b0;
    end else if (shift) begin
      win[0] <= din;
      for (int i = 1; i < WIN_LEN; i++) win[i] <= win[i-1];
      center <= addr - ADDR_W'(IMG_W + 1);
      center_ok <= addr >= ADDR_W'(IMG_W + 1);
    end
  // taps[0..7] are neighbours k0..k7, taps[8] is the center
  assign taps = {win[IMG_W+1], win[0], win[1], win[2], win[IMG_W], win[IMG_W+2],
                 win[2*IMG_W], win[2*IMG_W+1], win[2*IMG_W+2]};
  assign center_row = center[ADDR_W-1:COL_W];
  assign center_col = center[COL_W-1:0];
endmodule

// File: rtl/lbp_engine.sv
// lbp_engine: streams an RGB frame to gray and LBP memories, one pixel per cycle
module lbp_engine
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] RGB_addr,
  output logic              RGB_req,
  input  logic              RGB_ready,
  input  logic [23:0]       RGB_data,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_valid,
  output logic [7:0]        gray_data,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_valid,
  output logic [7:0]        lbp_data,
  output logic              finish
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
  logic [ADDR_W-1:0] cnt, addr_d, center;
  logic              fetch_done, req_d, center_ok, border;
  logic [7:0]        gray_in, code;
  logic [8:0][7:0]   taps;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  rgb_t              px;
  state_t            state;
  assign px = RGB_data;
  assign gray_in = div3(10'(px.r) + 10'(px.g) + 10'(px.b));
  assign RGB_req = reset && RGB_ready && !fetch_done;
  assign RGB_addr = cnt;
  assign border = row == '0 || row == ROW_W'(IMG_H - 1) || col == '0 || col == '1;
  always_comb begin
    code = '0;
    for (int k = 0; k < 8; k++) code[k] = taps[k] >= taps[8];
  end
  lbp_window u_win (
    .clk(clk), .reset(reset), .shift(req_d), .din(gray_in), .addr(addr_d),
    .taps(taps), .center(center), .center_ok(center_ok),
    .center_row(row), .center_col(col)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      fetch_done <= 1'b0;
      req_d <= 1'b0;
      addr_d <= '0;
      gray_valid <= 1'b0;
      gray_addr <= '0;
      gray_data <= '0;
      lbp_valid <= 1'b0;
      lbp_addr <= '0;
      lbp_data <= '0;
      finish <= 1'b0;
      state <= S_RUN;
    end else begin
      if (RGB_req) begin
        cnt <= (cnt == LAST) ? cnt : cnt + 1'b1;
        fetch_done <= cnt == LAST;
      end
      req_d <= RGB_req;
      addr_d <= cnt;
      gray_valid <= req_d;
      if (req_d) begin
        gray_addr <= addr_d;
        gray_data <= gray_in;
      end
      lbp_valid <= 1'b0;
      case (state)
        S_RUN:
          if (gray_valid && center_ok) begin
            lbp_valid <= 1'b1;
            lbp_addr <= center;
            lbp_data <= border ? 8'd0 : code;
            if (gray_addr == LAST) state <= S_FLUSH;
          end
        // the last IMG_W+1 pixels never reach the window center; all are border
        S_FLUSH: begin
          lbp_valid <= 1'b1;
          lbp_addr <= lbp_addr + 1'b1;
          lbp_data <= 8'd0;
          if (lbp_addr == LAST - 1'b1) state <= S_DONE;
        end
        default: finish <= 1'b1;
      endcase
    end
endmodule

// File: tb/tb_lbp_engine.sv
// tb_lbp_engine: directed frame tests against an array-based gray/LBP reference model
module tb_lbp_engine;
  localparam int W = 128, H = 128, N = W * H;
  logic clk = 1'b0, reset = 1'b1, RGB_ready = 1'b0;
  logic [23:0] RGB_data;
  logic [13:0] RGB_addr, gray_addr, lbp_addr;
  logic RGB_req, gray_valid, lbp_valid, finish;
  logic [7:0] gray_data, lbp_data;
  logic [23:0] rgb_mem [N];
  logic [7:0] gexp [N], lexp [N], ggot [N], lgot [N];
  int gcnt [N], lcnt [N];
  int cyc = 0, last_cyc = -1, fin_cyc = -1, late = 0, stall_w = 0;
  bit stall_mon = 1'b0;
  int errors = 0, checks = 0;
  int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  lbp_engine dut (
    .clk(clk), .reset(reset), .RGB_addr(RGB_addr), .RGB_req(RGB_req), .RGB_ready(RGB_ready),
    .RGB_data(RGB_data), .gray_addr(gray_addr), .gray_valid(gray_valid), .gray_data(gray_data),
    .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (RGB_req) RGB_data <= rgb_mem[RGB_addr];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (gray_valid) begin ggot[gray_addr] <= gray_data; gcnt[gray_addr] <= gcnt[gray_addr] + 1; end
    if (lbp_valid) begin lgot[lbp_addr] <= lbp_data; lcnt[lbp_addr] <= lcnt[lbp_addr] + 1; end
    if (lbp_valid && lbp_addr == 14'(N - 1)) last_cyc <= cyc;
    if (finish && fin_cyc < 0) fin_cyc <= cyc;
    if (finish && (gray_valid || lbp_valid)) late <= late + 1;
    if (stall_mon && (gray_valid || lbp_valid)) stall_w <= stall_w + 1;
  end

  task automatic build_model();
    for (int n = 0; n < N; n++)
      gexp[n] = 8'((int'(rgb_mem[n][23:16]) + int'(rgb_mem[n][15:8]) + int'(rgb_mem[n][7:0])) / 3);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        logic [7:0] v;
        v = 8'd0;
        if (r != 0 && r != H - 1 && c != 0 && c != W - 1)
          for (int k = 0; k < 8; k++) v[k] = gexp[(r + dr[k]) * W + c + dc[k]] >= gexp[r * W + c];
        lexp[r * W + c] = v;
      end
  endtask

  task automatic start_frame();
    reset = 1'b0;
    RGB_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin gcnt[i] <= 0; lcnt[i] <= 0; ggot[i] <= 8'd0; lgot[i] <= 8'd0; end
    late <= 0; stall_w <= 0; fin_cyc <= -1; last_cyc <= -1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_finish(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = finish;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_addr(input int a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      found = RGB_addr == 14'(a);
    end
  endtask

  task automatic audit(output int gbad, output int lbad);
    gbad = 0; lbad = 0;
    for (int n = 0; n < N; n++) begin
      if (gcnt[n] != 1 || ggot[n] !== gexp[n]) gbad++;
      if (lcnt[n] != 1 || lgot[n] !== lexp[n]) lbad++;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    RGB_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (RGB_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", RGB_req); end
    checks++; if (RGB_addr !== 14'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", RGB_addr); end
    checks++; if (gray_valid !== 1'b0) begin errors++; $display("FAIL reset_gvalid: got %0b want 0", gray_valid); end
    checks++; if (gray_data !== 8'd0) begin errors++; $display("FAIL reset_gdata: got %0h want 0", gray_data); end
    checks++; if (lbp_valid !== 1'b0) begin errors++; $display("FAIL reset_lvalid: got %0b want 0", lbp_valid); end
    checks++; if (lbp_addr !== 14'd0) begin errors++; $display("FAIL reset_laddr: got %0d want 0", lbp_addr); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %0b want 0", finish); end
  endtask

  task automatic test_white();
    bit ok; int gb, lb;
    for (int n = 0; n < N; n++) rgb_mem[n] = 24'hFFFFFF;
    build_model();
    start_frame();
    wait_finish(ok);
    audit(gb, lb);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL white_finish: got %0b want 1", ok); end
    checks++; if (gb !== 0) begin errors++; $display("FAIL white_gray: got %0d bad entries want 0", gb); end
    checks++; if (lb !== 0) begin errors++; $display("FAIL white_lbp: got %0d bad entries want 0", lb); end
    checks++; if (lgot[129] !== 8'hFF) begin errors++; $display("FAIL white_lbp129: got %0h want ff", lgot[129]); end
    checks++; if (lgot[N-1] !== 8'h00) begin errors++; $display("FAIL white_lbplast: got %0h want 0", lgot[N-1]); end
    checks++; if (fin_cyc - last_cyc !== 1) begin errors++; $display("FAIL white_fin_gap: got %0d want 1", fin_cyc - last_cyc); end
    checks++; if (late !== 0) begin errors++; $display("FAIL white_late_writes: got %0d want 0", late); end
  endtask

  task automatic test_single_pixel();
    bit ok; int gb, lb;
    for (int n = 0; n < N; n++) rgb_mem[n] = 24'h000000;
    rgb_mem[0] = 24'h102030; rgb_mem[1000] = 24'h010000;
    rgb_mem[1001] = 24'h030303; rgb_mem[1002] = 24'hFF0000;
    build_model();
    start_frame();
    @(negedge clk);
    checks++; if (gray_valid !== 1'b0) begin errors++; $display("FAIL lat_early: got %0b want 0", gray_valid); end
    checks++; if (RGB_addr !== 14'd1) begin errors++; $display("FAIL lat_addr: got %0d want 1", RGB_addr); end
    @(negedge clk);
    checks++; if ({gray_valid, gray_addr, gray_data} !== {1'b1, 14'd0, 8'd32})
      begin errors++; $display("FAIL lat_gray: got v=%0b a=%0d d=%0d want v=1 a=0 d=32", gray_valid, gray_addr, gray_data); end
    wait_finish(ok);
    audit(gb, lb);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_finish: got %0b want 1", ok); end
    checks++; if (gb !== 0) begin errors++; $display("FAIL single_gray: got %0d bad entries want 0", gb); end
    checks++; if (lb !== 0) begin errors++; $display("FAIL single_lbp: got %0d bad entries want 0", lb); end
    checks++; if (ggot[1000] !== 8'd0) begin errors++; $display("FAIL trunc_010000: got %0d want 0", ggot[1000]); end
    checks++; if (ggot[1001] !== 8'd3) begin errors++; $display("FAIL gray_030303: got %0d want 3", ggot[1001]); end
    checks++; if (ggot[1002] !== 8'd85) begin errors++; $display("FAIL gray_ff0000: got %0d want 85", ggot[1002]); end
    checks++; if (lgot[129] !== 8'hFF) begin errors++; $display("FAIL single_lbp129: got %0h want ff", lgot[129]); end
    checks++; if (lgot[0] !== 8'h00) begin errors++; $display("FAIL single_lbp0: got %0h want 0", lgot[0]); end
    checks++; if (lgot[1001] !== 8'h10) begin errors++; $display("FAIL single_lbp1001: got %0h want 10", lgot[1001]); end
    checks++; if (lgot[1002] !== 8'h00) begin errors++; $display("FAIL single_lbp1002: got %0h want 0", lgot[1002]); end
  endtask

  task automatic test_ramp_stall();
    bit ok, found; int gb, lb, bad_req; logic [13:0] held;
    for (int n = 0; n < N; n++) rgb_mem[n] = {3{8'(n % W)}};
    build_model();
    start_frame();
    wait_addr(6000, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL stall_reach: got %0b want 1", found); end
    RGB_ready = 1'b0;
    held = RGB_addr;
    bad_req = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (RGB_req !== 1'b0) bad_req++;
      if (i == 2) stall_mon = 1'b1;
    end
    stall_mon = 1'b0;
    checks++; if (bad_req !== 0) begin errors++; $display("FAIL stall_req: got %0d high cycles want 0", bad_req); end
    checks++; if (stall_w !== 0) begin errors++; $display("FAIL stall_writes: got %0d want 0", stall_w); end
    checks++; if (RGB_addr !== held) begin errors++; $display("FAIL stall_addr: got %0d want %0d", RGB_addr, held); end
    RGB_ready = 1'b1;
    wait_finish(ok);
    audit(gb, lb);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ramp_finish: got %0b want 1", ok); end
    checks++; if (gb !== 0) begin errors++; $display("FAIL ramp_gray: got %0d bad entries want 0", gb); end
    checks++; if (lb !== 0) begin errors++; $display("FAIL ramp_lbp: got %0d bad entries want 0", lb); end
    checks++; if (lgot[130] !== 8'hD6) begin errors++; $display("FAIL ramp_lbp130: got %0h want d6", lgot[130]); end
    checks++; if (lgot[128] !== 8'h00) begin errors++; $display("FAIL ramp_lbp128: got %0h want 0", lgot[128]); end
    checks++; if (lgot[255] !== 8'h00) begin errors++; $display("FAIL ramp_lbp255: got %0h want 0", lgot[255]); end
    checks++; if (late !== 0) begin errors++; $display("FAIL ramp_late_writes: got %0d want 0", late); end
  endtask

  task automatic test_reset_mid();
    bit ok, found; int gb, lb;
    for (int n = 0; n < N; n++) rgb_mem[n] = {8'(n * 7), 8'((n >> 3) ^ n), 8'(n * 13 + 5)};
    build_model();
    start_frame();
    wait_addr(8000, found);
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach: got %0b want 1", found); end
    reset = 1'b0;
    #1;
    checks++; if ({RGB_req, gray_valid, lbp_valid, finish} !== 4'b0000)
      begin errors++; $display("FAIL mid_flags: got %b want 0000", {RGB_req, gray_valid, lbp_valid, finish}); end
    checks++; if ({RGB_addr, gray_addr, lbp_addr} !== 42'd0)
      begin errors++; $display("FAIL mid_addrs: got %0d/%0d/%0d want 0/0/0", RGB_addr, gray_addr, lbp_addr); end
    start_frame();
    wait_finish(ok);
    audit(gb, lb);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_finish: got %0b want 1", ok); end
    checks++; if (gb !== 0) begin errors++; $display("FAIL mid_gray: got %0d bad entries want 0", gb); end
    checks++; if (lb !== 0) begin errors++; $display("FAIL mid_lbp: got %0d bad entries want 0", lb); end
  endtask

  initial begin
    test_reset();
    test_white();
    test_single_pixel();
    test_ramp_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
